// File: rtl/gb_top_if.sv
// Memory/debug bus of the gb_top SM83 core: fetch address, read strobe,
// combinational read data and the debug byte.
interface gb_top_if #(
    parameter int DATA_SIZE = 8,
    parameter int ADDR_SIZE = 16
);
    logic [DATA_SIZE-1:0] testing_data;
    logic [DATA_SIZE-1:0] data_out;
    logic                 rd;
    logic [ADDR_SIZE-1:0] addr_bus;

    modport master (
        output testing_data,
        input  data_out,
        input  rd,
        input  addr_bus
    );

    modport slave (
        input  testing_data,
        output data_out,
        output rd,
        output addr_bus
    );
endinterface

// File: rtl/gb_top.sv
// Minimal SM83 core with internal 64 KiB memory; 4 T-cycles per M-cycle.
// Define TESTING_DATA_EN to make opcode 0xD3 load testing_data into A.
module gb_top #(
    parameter int DATA_SIZE = 8,
    parameter int ADDR_SIZE = 16
) (
    input logic     clk,
    input logic     rst,
    gb_top_if.slave bus
);
    localparam int MEM_DEPTH = 1 << ADDR_SIZE;

    typedef enum logic [1:0] {
        MC_FETCH,
        MC_OPND,
        MC_HL_RD,
        MC_HL_WR
    } mcyc_t;

    typedef enum logic [3:0] {
        OP_NOP,
        OP_LD_RR,
        OP_LD_R_HL,
        OP_LD_HL_R,
        OP_LD_R_D8,
        OP_LD_HL_D8,
        OP_ALU_R,
        OP_ALU_HL,
        OP_ALU_D8,
        OP_INC,
        OP_DEC,
        OP_STOP,
        OP_TDATA
    } op_t;

    function automatic op_t decode(input logic [DATA_SIZE-1:0] op);
        op_t cls;
        cls = OP_NOP;
        case (op[7:6])
            2'b00: begin
                if (op == 8'h10)
                    cls = OP_STOP;
                else if (op[2:0] == 3'd6)
                    cls = (op[5:3] == 3'd6) ? OP_LD_HL_D8 : OP_LD_R_D8;
                else if (op[2:0] == 3'd4 && op[5:3] != 3'd6)
                    cls = OP_INC;
                else if (op[2:0] == 3'd5 && op[5:3] != 3'd6)
                    cls = OP_DEC;
            end
            2'b01: begin
                if (op == 8'h76)
                    cls = OP_NOP;
                else if (op[2:0] == 3'd6)
                    cls = OP_LD_R_HL;
                else if (op[5:3] == 3'd6)
                    cls = OP_LD_HL_R;
                else
                    cls = OP_LD_RR;
            end
            2'b10: cls = (op[2:0] == 3'd6) ? OP_ALU_HL : OP_ALU_R;
            default: begin
                if (op[2:0] == 3'd6)
                    cls = OP_ALU_D8;
`ifdef TESTING_DATA_EN
                else if (op == 8'hD3)
                    cls = OP_TDATA;
`endif
            end
        endcase
        return cls;
    endfunction

    function automatic logic [1:0] mcount(input op_t cls);
        case (cls)
            OP_LD_R_HL, OP_LD_HL_R, OP_LD_R_D8, OP_ALU_HL, OP_ALU_D8: return 2'd2;
            OP_LD_HL_D8: return 2'd3;
            default:     return 2'd1;
        endcase
    endfunction

    function automatic mcyc_t next_kind(input op_t cls, input logic [1:0] m_next);
        case (cls)
            OP_LD_R_HL, OP_ALU_HL: return MC_HL_RD;
            OP_LD_HL_R:            return MC_HL_WR;
            OP_LD_R_D8, OP_ALU_D8: return MC_OPND;
            OP_LD_HL_D8:           return (m_next == 2'd1) ? MC_OPND : MC_HL_WR;
            default:               return MC_FETCH;
        endcase
    endfunction

    logic [DATA_SIZE-1:0] r_a, r_b, r_c, r_d, r_e, r_h, r_l;
    logic [7:0]           r_f;
    logic [ADDR_SIZE-1:0] r_pc;
    logic [1:0]           r_t_cycle;
    logic [1:0]           r_m_cycle;
    logic [1:0]           r_m_count;
    logic                 r_hold;
    logic                 r_rd;
    logic [ADDR_SIZE-1:0] r_addr;
    mcyc_t                r_mc;
    logic [DATA_SIZE-1:0] r_ir;
    logic [DATA_SIZE-1:0] r_opnd;
    logic [DATA_SIZE-1:0] r_mem [MEM_DEPTH];

    logic                 w_m1t1;
    logic                 w_last;
    logic [DATA_SIZE-1:0] w_data;
    op_t                  w_cls;
    mcyc_t                w_next_mc;
    logic [DATA_SIZE-1:0] w_src;
    logic [DATA_SIZE-1:0] w_dst;
    logic                 w_cin;
    logic [DATA_SIZE:0]   w_sum;
    logic [DATA_SIZE:0]   w_diff;
    logic [DATA_SIZE-1:0] w_alu;
    logic [7:0]           w_alu_f;
    logic [DATA_SIZE-1:0] w_incdec;
    logic                 w_wr_en;
    logic [2:0]           w_wr_idx;
    logic [DATA_SIZE-1:0] w_wr_val;
    logic                 w_f_en;
    logic [7:0]           w_f_val;
    logic                 w_stop;

    assign w_data        = r_mem[r_addr];
    assign w_m1t1        = (r_m_cycle == 2'd0) && (r_t_cycle == 2'd0);
    assign w_last        = (r_m_cycle == r_m_count - 2'd1);
    assign w_cls         = decode(r_ir);
    assign w_next_mc     = next_kind(w_cls, r_m_cycle + 2'd1);
    assign bus.data_out  = w_data;
    assign bus.rd        = r_rd;
    assign bus.addr_bus  = r_addr;

    // Index 6 ((HL)) selects the latched operand, which also serves every d8 form.
    always_comb begin
        w_src = r_opnd;
        case (r_ir[2:0])
            3'd0:    w_src = r_b;
            3'd1:    w_src = r_c;
            3'd2:    w_src = r_d;
            3'd3:    w_src = r_e;
            3'd4:    w_src = r_h;
            3'd5:    w_src = r_l;
            3'd7:    w_src = r_a;
            default: w_src = r_opnd;
        endcase
    end

    always_comb begin
        w_dst = r_a;
        case (r_ir[5:3])
            3'd0:    w_dst = r_b;
            3'd1:    w_dst = r_c;
            3'd2:    w_dst = r_d;
            3'd3:    w_dst = r_e;
            3'd4:    w_dst = r_h;
            3'd5:    w_dst = r_l;
            default: w_dst = r_a;
        endcase
    end

    // Carry-in only for ADC (op 1) and SBC (op 3).
    always_comb begin
        w_cin   = r_f[4] & r_ir[3] & ~r_ir[5];
        w_sum   = {1'b0, r_a} + {1'b0, w_src} + {{DATA_SIZE{1'b0}}, w_cin};
        w_diff  = {1'b0, r_a} - {1'b0, w_src} - {{DATA_SIZE{1'b0}}, w_cin};
        w_alu   = '0;
        w_alu_f = '0;
        case (r_ir[5:3])
            3'd0, 3'd1: begin
                w_alu      = w_sum[DATA_SIZE-1:0];
                w_alu_f[5] = ({1'b0, r_a[3:0]} + {1'b0, w_src[3:0]} + {4'b0000, w_cin}) > 5'd15;
                w_alu_f[4] = w_sum[DATA_SIZE];
            end
            3'd4: begin
                w_alu      = r_a & w_src;
                w_alu_f[5] = 1'b1;
            end
            3'd5: w_alu = r_a ^ w_src;
            3'd6: w_alu = r_a | w_src;
            default: begin
                w_alu      = w_diff[DATA_SIZE-1:0];
                w_alu_f[6] = 1'b1;
                w_alu_f[5] = {1'b0, r_a[3:0]} < ({1'b0, w_src[3:0]} + {4'b0000, w_cin});
                w_alu_f[4] = w_diff[DATA_SIZE];
            end
        endcase
        w_alu_f[7] = (w_alu == '0);
    end

    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_idx = r_ir[5:3];
        w_wr_val = w_src;
        w_f_en   = 1'b0;
        w_f_val  = r_f;
        w_stop   = 1'b0;
        w_incdec = (w_cls == OP_DEC) ? w_dst - DATA_SIZE'(1) : w_dst + DATA_SIZE'(1);
        case (w_cls)
            OP_LD_RR, OP_LD_R_HL, OP_LD_R_D8: w_wr_en = 1'b1;
            OP_ALU_R, OP_ALU_HL, OP_ALU_D8: begin
                w_wr_en  = (r_ir[5:3] != 3'd7);
                w_wr_idx = 3'd7;
                w_wr_val = w_alu;
                w_f_en   = 1'b1;
                w_f_val  = w_alu_f;
            end
            OP_INC: begin
                w_wr_en  = 1'b1;
                w_wr_val = w_incdec;
                w_f_en   = 1'b1;
                w_f_val  = {(w_incdec == '0), 1'b0, (w_dst[3:0] == 4'hF), r_f[4], 4'b0000};
            end
            OP_DEC: begin
                w_wr_en  = 1'b1;
                w_wr_val = w_incdec;
                w_f_en   = 1'b1;
                w_f_val  = {(w_incdec == '0), 1'b1, (w_dst[3:0] == 4'h0), r_f[4], 4'b0000};
            end
            OP_STOP: w_stop = 1'b1;
            OP_TDATA: begin
                w_wr_en  = 1'b1;
                w_wr_idx = 3'd7;
                w_wr_val = bus.testing_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_c       <= '0;
            r_d       <= '0;
            r_e       <= '0;
            r_h       <= '0;
            r_l       <= '0;
            r_f       <= '0;
            r_pc      <= '0;
            r_t_cycle <= '0;
            r_m_cycle <= '0;
            r_m_count <= 2'd1;
            r_hold    <= 1'b0;
            r_rd      <= 1'b1;
            r_addr    <= '0;
            r_mc      <= MC_FETCH;
            r_ir      <= '0;
            r_opnd    <= '0;
        end else begin
            r_t_cycle <= r_t_cycle + 2'd1;

            // Bus address and strobe are set up for the whole next M-cycle at the T4 edge.
            if (r_t_cycle == 2'd3) begin
                if (w_last) begin
                    r_m_cycle <= '0;
                    r_mc      <= MC_FETCH;
                    r_addr    <= r_pc;
                    r_rd      <= 1'b1;
                end else begin
                    r_m_cycle <= r_m_cycle + 2'd1;
                    r_mc      <= w_next_mc;
                    r_addr    <= (w_next_mc == MC_OPND) ? r_pc : {r_h, r_l};
                    r_rd      <= (w_next_mc != MC_HL_WR);
                end
            end

            if (r_t_cycle == 2'd0) begin
                if (w_m1t1) begin
                    r_ir      <= w_data;
                    r_m_count <= mcount(decode(w_data));
                    if (!r_hold)
                        r_pc <= r_pc + ADDR_SIZE'(1);
                end else if (r_mc == MC_OPND) begin
                    r_opnd <= w_data;
                    if (!r_hold)
                        r_pc <= r_pc + ADDR_SIZE'(1);
                end else if (r_mc == MC_HL_RD) begin
                    r_opnd <= w_data;
                end
            end

            if (r_t_cycle == 2'd1 && w_last && !r_hold) begin
                if (w_wr_en) begin
                    case (w_wr_idx)
                        3'd0:    r_b <= w_wr_val;
                        3'd1:    r_c <= w_wr_val;
                        3'd2:    r_d <= w_wr_val;
                        3'd3:    r_e <= w_wr_val;
                        3'd4:    r_h <= w_wr_val;
                        3'd5:    r_l <= w_wr_val;
                        3'd7:    r_a <= w_wr_val;
                        default: ;
                    endcase
                end
                if (w_f_en)
                    r_f <= w_f_val;
                if (w_stop)
                    r_hold <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && r_t_cycle == 2'd1 && r_mc == MC_HL_WR && !r_hold)
            r_mem[{r_h, r_l}] <= w_src;
    end
endmodule

// File: tb/tb_gb_top.sv
// Directed bench for gb_top: programs preloaded into memory, expected register
// snapshots queued per instruction and compared at T3 of each last M-cycle.
module tb_gb_top;
    logic clk = 1'b0;
    logic rst = 1'b1;

    gb_top_if #(.DATA_SIZE(8), .ADDR_SIZE(16)) bus ();

    gb_top #(.DATA_SIZE(8), .ADDR_SIZE(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  a, b, c, d, e, h, l, f;
        logic [15:0] pc;
        logic        hold;
    } regs_t;

    regs_t sb[$];
    string tags[$];
    regs_t m;
    int    n_checks = 0;
    int    n_fail   = 0;
    int    neg_cnt  = 0;
    int    last_pop = 0;
    int    last_len = 0;

    task automatic chk(input string tag, input logic [80:0] obs, input logic [80:0] req);
        n_checks++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, req);
        end
    endtask

    function automatic void push(input string tag);
        sb.push_back(m);
        tags.push_back(tag);
    endfunction

    function automatic regs_t observe();
        regs_t o;
        o = {dut.r_a, dut.r_b, dut.r_c, dut.r_d, dut.r_e, dut.r_h, dut.r_l,
             dut.r_f, dut.r_pc, dut.r_hold};
        return o;
    endfunction

    task automatic load_and_reset(input logic [7:0] prog[$]);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 32; i++)
            dut.r_mem[i] = (i < prog.size()) ? prog[i] : 8'h00;
        dut.r_mem[16'hC000] = 8'h00;
        @(negedge clk);
        chk("reset_regs", 81'(observe()), 81'(0));
        chk("reset_ctrl", 81'({dut.r_t_cycle, dut.r_m_cycle, dut.r_m_count, bus.rd, bus.addr_bus}),
            81'({2'd0, 2'd0, 2'd1, 1'b1, 16'h0000}));
        rst = 1'b0;
        m = '0;
        sb.delete();
        tags.delete();
        neg_cnt  = 0;
        last_pop = 0;
    endtask

    task automatic run(input int n);
        int    done;
        int    budget;
        regs_t req;
        string tag;
        done   = 0;
        budget = 0;
        while (done < n && budget < 20 * n + 20) begin
            @(negedge clk);
            budget++;
            neg_cnt++;
            if (dut.r_t_cycle == 2'd2 && dut.r_m_cycle == dut.r_m_count - 2'd1) begin
                if (sb.size() > 0) begin
                    req = sb.pop_front();
                    tag = tags.pop_front();
                    chk(tag, 81'(observe()), 81'(req));
                end
                last_len = neg_cnt - last_pop;
                last_pop = neg_cnt;
                done++;
            end
        end
        chk("instr_budget", 81'(done), 81'(n));
    endtask

    initial begin
        bus.testing_data = 8'h01;

        // ADD, then STOP freezes PC and refetches the same address
        load_and_reset({8'h3E, 8'h12, 8'h06, 8'h34, 8'h80, 8'h10});
        m.a = 8'h12; m.pc = 16'd2; push("ld_a_d8");
        m.b = 8'h34; m.pc = 16'd4; push("ld_b_d8");
        m.a = 8'h46; m.f = 8'h00; m.pc = 16'd5; push("add_a_b");
        m.pc = 16'd6; m.hold = 1'b1; push("stop");
        run(4);
        chk("stop_data_out", 81'(bus.data_out), 81'(8'h10));
        push("hold_refetch");
        run(1);

        // ADD overflow, optional debug load, INC/DEC keep carry
        load_and_reset({8'h3E, 8'hFF, 8'hC6, 8'h01, 8'hD3, 8'h3C, 8'h05});
        m.a = 8'hFF; m.pc = 16'd2; push("ld_a_ff");
        m.a = 8'h00; m.f = 8'hB0; m.pc = 16'd4; push("add_wrap");
`ifdef TESTING_DATA_EN
        m.a = 8'h01;
`else
        m.a = 8'h00;
`endif
        m.pc = 16'd5; push("op_d3");
        m.a = m.a + 8'h01; m.f = 8'h10; m.pc = 16'd6; push("inc_a");
        m.b = 8'hFF; m.f = 8'h70; m.pc = 16'd7; push("dec_b");
        run(5);

        // (HL) write and reads, HALT as NOP
        load_and_reset({8'h26, 8'hC0, 8'h2E, 8'h00, 8'h36, 8'h5A, 8'h7E, 8'h86, 8'h46, 8'h76});
        m.h = 8'hC0; m.pc = 16'd2; push("ld_h");
        m.l = 8'h00; m.pc = 16'd4; push("ld_l");
        run(2);
        m.pc = 16'd6; push("ld_hl_d8");
        run(1);
        chk("ld_hl_d8_clocks", 81'(last_len), 81'(12));
        chk("ld_hl_d8_bus", 81'({bus.rd, bus.addr_bus}), 81'({1'b0, 16'hC000}));
        chk("mem_c000", 81'(dut.r_mem[16'hC000]), 81'(8'h5A));
        m.a = 8'h5A; m.pc = 16'd7; push("ld_a_hl");
        m.a = 8'hB4; m.f = 8'h20; m.pc = 16'd8; push("add_a_hl");
        m.b = 8'h5A; m.pc = 16'd9; push("ld_b_hl");
        m.pc = 16'd10; push("halt_nop");
        run(4);

        // CP, then DEC A from zero
        load_and_reset({8'h3E, 8'h10, 8'hFE, 8'h10, 8'h3E, 8'h00, 8'h3D});
        m.a = 8'h10; m.pc = 16'd2; push("ld_a_10");
        m.f = 8'hC0; m.pc = 16'd4; push("cp_equal");
        m.a = 8'h00; m.pc = 16'd6; push("ld_a_00");
        m.a = 8'hFF; m.f = 8'h60; m.pc = 16'd7; push("dec_a_wrap");
        run(4);

        // Remaining ALU ops, LD r,r', INC/DEC, unsupported opcode
        load_and_reset({8'h3E, 8'hF0, 8'hC6, 8'h20, 8'hCE, 8'h05, 8'hD6, 8'h20,
                        8'hDE, 8'h01, 8'hE6, 8'h0F, 8'hEE, 8'h04, 8'h47, 8'h0E,
                        8'h3C, 8'hB1, 8'h91, 8'h14, 8'h1D, 8'h23});
        m.a = 8'hF0; m.pc = 16'd2; push("ld_a_f0");
        m.a = 8'h10; m.f = 8'h10; m.pc = 16'd4; push("add_carry");
        m.a = 8'h16; m.f = 8'h00; m.pc = 16'd6; push("adc");
        m.a = 8'hF6; m.f = 8'h50; m.pc = 16'd8; push("sub_borrow");
        m.a = 8'hF4; m.f = 8'h40; m.pc = 16'd10; push("sbc");
        m.a = 8'h04; m.f = 8'h20; m.pc = 16'd12; push("and");
        m.a = 8'h00; m.f = 8'h80; m.pc = 16'd14; push("xor_zero");
        m.b = 8'h00; m.pc = 16'd15; push("ld_b_a");
        m.c = 8'h3C; m.pc = 16'd17; push("ld_c_d8");
        m.a = 8'h3C; m.f = 8'h00; m.pc = 16'd18; push("or_c");
        m.a = 8'h00; m.f = 8'hC0; m.pc = 16'd19; push("sub_c");
        m.d = 8'h01; m.f = 8'h00; m.pc = 16'd20; push("inc_d");
        m.e = 8'hFF; m.f = 8'h60; m.pc = 16'd21; push("dec_e");
        m.pc = 16'd22; push("unsupported_nop");
        run(14);

        // Reset in M2 of LD B,d8, before its writeback
        load_and_reset({8'h06, 8'h77});
        repeat (5) @(negedge clk);
        chk("mid_instr", 81'({dut.r_pc, dut.r_b, dut.r_m_cycle}), 81'({16'd2, 8'h00, 2'd1}));
        rst = 1'b1;
        @(negedge clk);
        chk("mid_reset_regs", 81'(observe()), 81'(0));
        chk("mid_reset_ctrl", 81'({dut.r_t_cycle, dut.r_m_cycle, bus.addr_bus}), 81'(0));
        rst = 1'b0;
        m = '0;
        neg_cnt  = 0;
        last_pop = 0;
        m.b = 8'h77; m.pc = 16'd2; push("restart_ld_b");
        run(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
